// File: rtl/i2c_engine_arbiter.sv
// rtl/i2c_engine_arbiter.sv - round-robin arbiter sharing one I2C byte engine between requesters
//
// Purpose: shares one I2C byte engine between NUM_REQ sequencers. Ownership is
// granted round-robin and stays locked for a whole transaction, which ends when
// the owner's step returns to 2'b00. After every owner the engine is held at
// 2'b00 for GAP_CYCLES cycles. A watchdog drops an owner whose engine shows no
// ready rising edge for TIMEOUT_CYC cycles.
//
// Ports:
//   clk            in   system clock, all logic on posedge
//   reset          in   asynchronous active-high reset
//   req_next_step  in   per-requester step, slice i = [2i+1:2i]
//   req_tx_byte    in   per-requester tx byte, slice i = [8i+7:8i]
//   req_ready      out  engine ready routed to the owner only
//   req_rx_byte    out  engine rx byte broadcast to all requesters
//   grant          out  registered one-hot owner, zero when nobody owns
//   eng_next_step  out  step to engine
//   eng_tx_byte    out  tx byte to engine
//   eng_ready      in   engine step-complete level, rising edge = step done
//   eng_rx_byte    in   byte received by engine
//   busy           out  high in GRANT and RELEASE
//   timeout_err    out  one-cycle pulse when the watchdog fires
module i2c_engine_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int GAP_CYCLES  = 4,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2*NUM_REQ-1:0]   req_next_step,
    input  logic [8*NUM_REQ-1:0]   req_tx_byte,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             req_rx_byte,
    output logic [NUM_REQ-1:0]     grant,
    output logic [1:0]             eng_next_step,
    output logic [7:0]             eng_tx_byte,
    input  logic                   eng_ready,
    input  logic [7:0]             eng_rx_byte,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT_CYC) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    state_t            state;
    logic [PW-1:0]     rr_ptr;
    logic [WW-1:0]     wd_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              ready_q;
    logic              ready_rise;

    logic [NUM_REQ-1:0] req_vec;
    logic [PW-1:0]      cand;
    logic [PW-1:0]      winner;
    logic               found;

    // Grant is one-hot, so OR-merging the granted slices is a plain mux.
    always_comb begin
        eng_next_step = 2'b00;
        eng_tx_byte   = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                eng_next_step = eng_next_step | req_next_step[2*i +: 2];
                eng_tx_byte   = eng_tx_byte | req_tx_byte[8*i +: 8];
            end
        end
    end

    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vec[i] = |req_next_step[2*i +: 2];
        end
    end

    assign req_ready   = grant & {NUM_REQ{eng_ready}};
    assign req_rx_byte = eng_rx_byte;
    assign ready_rise  = eng_ready & ~ready_q;

    // Search starts one past the last winner and wraps, so the previous owner
    // is considered last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_vec[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= eng_ready;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= PW'(NUM_REQ - 1);
            wd_cnt      <= '0;
            gap_cnt     <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    wd_cnt  <= '0;
                    gap_cnt <= '0;
                    if (found) begin
                        grant  <= NUM_REQ'(1) << winner;
                        rr_ptr <= winner;
                        busy   <= 1'b1;
                        state  <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (eng_next_step == 2'b00) begin
                        grant   <= '0;
                        gap_cnt <= '0;
                        wd_cnt  <= '0;
                        state   <= S_RELEASE;
                    end else if (wd_cnt == WW'(TIMEOUT_CYC - 1)) begin
                        grant       <= '0;
                        timeout_err <= 1'b1;
                        gap_cnt     <= '0;
                        wd_cnt      <= '0;
                        state       <= S_RELEASE;
                    end else if (ready_rise) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt != {WW{1'b1}}) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    wd_cnt <= '0;
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
